// File: rtl/matrix_pkg.sv
// Shared defaults and FSM encoding for the matrix storage controller.
package matrix_pkg;

  localparam int MAT_SLOTS      = 8;
  localparam int MAT_SLOT_WORDS = 32;
  localparam int MAT_MAX_DIM    = 5;
  localparam int MAT_DW         = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/slot_alloc.sv
// Slot allocator: lowest free slot, or round-robin victim once every slot is valid.
module slot_alloc
  import matrix_pkg::*;
#(
  parameter int  SLOTS = MAT_SLOTS,
  localparam int SW    = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [SLOTS-1:0] slot_valid,
  output logic [SW-1:0]    slot,
  output logic             full
);

  logic [SW-1:0] victim;
  logic [SW-1:0] first_free;
  logic          found;

  always_comb begin
    first_free = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!found && !slot_valid[i]) begin
        first_free = SW'(i);
        found      = 1'b1;
      end
    end
  end

  assign full = &slot_valid;
  assign slot = full ? victim : first_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim <= '0;
    end else if (clear) begin
      victim <= '0;
    end else if (advance) begin
      victim <= (victim == SW'(SLOTS - 1)) ? '0 : victim + SW'(1);
    end
  end

endmodule

// File: rtl/matrix_storage_ctrl.sv
// Owner of the matrix storage port: arbitrates one writer and one reader and
// keeps per-slot metadata (valid, rows, cols).
module matrix_storage_ctrl
  import matrix_pkg::*;
#(
  parameter int  SLOTS      = MAT_SLOTS,
  parameter int  SLOT_WORDS = MAT_SLOT_WORDS,
  parameter int  MAX_DIM    = MAT_MAX_DIM,
  parameter int  DW         = MAT_DW,
  localparam int SW         = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [2:0]       wr_rows,
  input  logic [2:0]       wr_cols,
  output logic             wr_gnt,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_done,
  output logic             wr_err,
  output logic [SW-1:0]    wr_slot,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot_in,
  output logic             rd_gnt,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DW-1:0]    rd_data,
  output logic             rd_last,
  output logic             rd_err,
  input  logic             clear,
  input  logic [SW-1:0]    q_slot,
  output logic [2:0]       q_rows,
  output logic [2:0]       q_cols,
  output logic [SLOTS-1:0] slot_valid,
  output logic             st_we,
  output logic [7:0]       st_addr,
  output logic [DW-1:0]    st_wdata,
  input  logic [DW-1:0]    st_rdata
);

  localparam logic [2:0] MAX3 = 3'(MAX_DIM);

  state_t        state, state_d;
  logic [SW-1:0] cur_slot;
  logic [SW-1:0] alloc_slot;
  logic          alloc_full;
  logic [2:0]    cur_rows, cur_cols;
  logic [4:0]    idx;
  logic [5:0]    count;
  logic [7:0]    base_addr;
  logic [2:0]    meta_rows [SLOTS];
  logic [2:0]    meta_cols [SLOTS];
  logic          dims_ok, rd_slot_ok, arb_ok, wr_take, rd_take;
  logic          wr_hs, rd_hs, at_last;

  assign dims_ok    = (wr_rows != 3'd0) && (wr_rows <= MAX3) &&
                      (wr_cols != 3'd0) && (wr_cols <= MAX3);
  assign rd_slot_ok = slot_valid[rd_slot_in];
  // A grant pulse still being shown blocks re-arbitration of the same held request.
  assign arb_ok     = (state == IDLE) && !wr_gnt && !rd_gnt;
  assign wr_take    = arb_ok && wr_req;
  assign rd_take    = arb_ok && !wr_req && rd_req;
  assign wr_hs      = wr_ready && wr_valid;
  assign rd_hs      = rd_valid && rd_ready;
  assign count      = 6'(cur_rows) * 6'(cur_cols);
  assign at_last    = ({1'b0, idx} == count - 6'd1);
  assign base_addr  = 8'(32'(cur_slot) * 32'(SLOT_WORDS));
  assign q_rows     = meta_rows[q_slot];
  assign q_cols     = meta_cols[q_slot];

  slot_alloc #(.SLOTS(SLOTS)) u_alloc (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .advance    (wr_take && dims_ok && alloc_full),
    .slot_valid (slot_valid),
    .slot       (alloc_slot),
    .full       (alloc_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (wr_take && dims_ok)         state_d = WRITE;
        else if (rd_take && rd_slot_ok) state_d = READ;
      end
      WRITE:   if (wr_hs && at_last) state_d = IDLE;
      READ:    if (rd_hs && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The grant cycle is already WRITE/READ, but the element path opens one cycle later.
  always_comb begin
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_data  = '0;
    st_we    = 1'b0;
    st_addr  = '0;
    st_wdata = '0;
    case (state)
      WRITE: if (!wr_gnt) begin
        wr_ready = 1'b1;
        st_we    = wr_valid;
        st_addr  = base_addr + {3'b000, idx};
        st_wdata = wr_data;
      end
      READ: if (!rd_gnt) begin
        rd_valid = 1'b1;
        st_addr  = base_addr + {3'b000, idx};
        rd_data  = st_rdata;
        rd_last  = at_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_gnt     <= 1'b0;
      wr_err     <= 1'b0;
      wr_done    <= 1'b0;
      wr_slot    <= '0;
      rd_gnt     <= 1'b0;
      rd_err     <= 1'b0;
      slot_valid <= '0;
      cur_slot   <= '0;
      cur_rows   <= '0;
      cur_cols   <= '0;
      idx        <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        meta_rows[i] <= '0;
        meta_cols[i] <= '0;
      end
    end else begin
      wr_gnt  <= wr_take;
      wr_err  <= wr_take && !dims_ok;
      rd_gnt  <= rd_take;
      rd_err  <= rd_take && !rd_slot_ok;
      wr_done <= wr_hs && at_last;

      if (wr_take && dims_ok) begin
        cur_slot <= alloc_slot;
        cur_rows <= wr_rows;
        cur_cols <= wr_cols;
        idx      <= '0;
      end else if (rd_take && rd_slot_ok) begin
        cur_slot <= rd_slot_in;
        cur_rows <= meta_rows[rd_slot_in];
        cur_cols <= meta_cols[rd_slot_in];
        idx      <= '0;
      end else if (wr_hs || rd_hs) begin
        idx <= idx + 5'd1;
      end

      if (clear) begin
        slot_valid <= '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
          meta_rows[i] <= '0;
          meta_cols[i] <= '0;
        end
      end else if (wr_take && dims_ok) begin
        slot_valid[alloc_slot] <= 1'b0;
        meta_rows[alloc_slot]  <= wr_rows;
        meta_cols[alloc_slot]  <= wr_cols;
      end

      // Completion wins over a concurrent clear for the slot just written.
      if (wr_hs && at_last) begin
        slot_valid[cur_slot] <= 1'b1;
        wr_slot              <= cur_slot;
      end
    end
  end

endmodule

// File: tb/tb_matrix_storage_ctrl.sv
// Directed bench for matrix_storage_ctrl with a slot-level reference model.
module tb_matrix_storage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [2:0]  wr_rows = '0, wr_cols = '0;
  logic        wr_gnt, wr_ready, wr_done, wr_err;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic [2:0]  wr_slot;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_slot_in = '0;
  logic        rd_gnt, rd_valid, rd_last, rd_err;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        clear = 1'b0;
  logic [2:0]  q_slot = '0;
  logic [2:0]  q_rows, q_cols;
  logic [7:0]  slot_valid;
  logic        st_we;
  logic [7:0]  st_addr;
  logic [31:0] st_wdata, st_rdata;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (st_we) ram[st_addr] <= st_wdata;
  assign st_rdata = ram[st_addr];

  matrix_storage_ctrl #(.SLOTS(8), .SLOT_WORDS(32), .MAX_DIM(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_rows(wr_rows), .wr_cols(wr_cols), .wr_gnt(wr_gnt),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_done(wr_done), .wr_err(wr_err), .wr_slot(wr_slot),
    .rd_req(rd_req), .rd_slot_in(rd_slot_in), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_err(rd_err),
    .clear(clear), .q_slot(q_slot), .q_rows(q_rows), .q_cols(q_cols),
    .slot_valid(slot_valid),
    .st_we(st_we), .st_addr(st_addr), .st_wdata(st_wdata), .st_rdata(st_rdata)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what each slot holds and which slots are valid.
  bit [7:0] m_valid;
  int       m_rows [8];
  int       m_cols [8];
  int       m_victim;
  int       m_mem  [8][25];
  bit       w_active, r_active, prev_clear;
  int       w_slot, w_cnt, w_n, r_slot, r_cnt, r_n;
  int       cyc, t_wr_gnt, t_wr_done, t_rd_gnt;
  int       got [$];

  function automatic int model_alloc();
    int v;
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
    v = m_victim;
    m_victim = (m_victim + 1) % 8;
    return v;
  endfunction

  function automatic void model_forget();
    m_valid  = '0;
    m_victim = 0;
    for (int i = 0; i < 8; i++) begin
      m_rows[i] = 0;
      m_cols[i] = 0;
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_forget();
      w_active = 1'b0; r_active = 1'b0; prev_clear = 1'b0;
    end else begin
      if (prev_clear) model_forget();
      prev_clear = clear;
      chk("one_grant", 32'(wr_gnt & rd_gnt), 0);
      if (wr_done) begin
        chk("wr_done_expected", 32'(w_active), 1);
        chk("wr_count", w_cnt, w_n);
        chk("wr_slot", 32'(wr_slot), w_slot);
        m_valid[w_slot] = 1'b1;
        w_active = 1'b0;
        t_wr_done = cyc;
      end
      if (wr_gnt) begin
        bit legal;
        legal = (wr_rows >= 1) && (wr_rows <= 5) && (wr_cols >= 1) && (wr_cols <= 5);
        chk("wr_err", 32'(wr_err), 32'(!legal));
        t_wr_gnt = cyc;
        if (legal) begin
          w_slot = model_alloc();
          m_valid[w_slot] = 1'b0;
          m_rows[w_slot] = int'(wr_rows);
          m_cols[w_slot] = int'(wr_cols);
          w_n = int'(wr_rows) * int'(wr_cols);
          w_cnt = 0;
          w_active = 1'b1;
        end
      end
      if (rd_gnt) begin
        chk("rd_err", 32'(rd_err), 32'(!m_valid[rd_slot_in]));
        t_rd_gnt = cyc;
        if (m_valid[rd_slot_in]) begin
          r_slot = int'(rd_slot_in);
          r_n = m_rows[r_slot] * m_cols[r_slot];
          r_cnt = 0;
          r_active = 1'b1;
        end
      end
      if (st_we) begin
        chk("st_we_expected", 32'(w_active && w_cnt < w_n), 1);
        chk("st_addr_wr", 32'(st_addr), w_slot * 32 + w_cnt);
        chk("st_wdata", st_wdata, wr_data);
        if (w_cnt < 25) m_mem[w_slot][w_cnt] = wr_data;
        w_cnt++;
      end
      if (rd_valid) begin
        chk("rd_valid_expected", 32'(r_active), 1);
        chk("rd_data", rd_data, (r_cnt < 25) ? m_mem[r_slot][r_cnt] : 0);
        chk("rd_last", 32'(rd_last), 32'(r_cnt == r_n - 1));
        if (rd_ready) begin
          got.push_back(int'(rd_data));
          r_cnt++;
          if (r_cnt == r_n) r_active = 1'b0;
        end
      end
      chk("slot_valid", 32'(slot_valid), 32'(m_valid));
      chk("q_rows", 32'(q_rows), m_rows[q_slot]);
      chk("q_cols", 32'(q_cols), m_cols[q_slot]);
    end
  end

  task automatic do_write(input int rows, input int cols, input int base, input int nsend,
                          output int slot, output bit err);
    int t;
    slot = -1;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_rows = 3'(rows); wr_cols = 3'(cols);
    t = 0;
    do begin @(negedge clk); t++; end while (!wr_gnt && t < 50);
    chk("wr_gnt_wait", 32'(wr_gnt), 1);
    err = wr_err;
    @(posedge clk); #1;
    wr_req = 1'b0;
    if (!err) begin
      for (int k = 0; k < nsend; k++) begin
        wr_valid = 1'b1; wr_data = 32'(base + k);
        @(posedge clk); #1;
      end
      wr_valid = 1'b0; wr_data = '0;
      if (nsend == rows * cols) begin
        t = 0;
        while (!wr_done && t < 10) begin @(negedge clk); t++; end
        chk("wr_done_wait", 32'(wr_done), 1);
        slot = int'(wr_slot);
      end
    end
  endtask

  task automatic do_read(input int slot, input bit toggle, output bit err);
    int t;
    bit fin;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_slot_in = 3'(slot);
    t = 0;
    do begin @(negedge clk); t++; end while (!rd_gnt && t < 50);
    chk("rd_gnt_wait", 32'(rd_gnt), 1);
    err = rd_err;
    @(posedge clk); #1;
    rd_req = 1'b0;
    if (!err) begin
      rd_ready = !toggle; fin = 1'b0; t = 0;
      while (!fin && t < 100) begin
        @(negedge clk);
        fin = rd_valid && rd_ready && rd_last;
        @(posedge clk); #1;
        if (toggle) rd_ready = !rd_ready;
        t++;
      end
      chk("rd_last_wait", 32'(fin), 1);
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit e;
    for (int i = 0; i < 256; i++) ram[i] = '0;

    #12;
    chk("rst_ctrl_outputs", 32'({wr_gnt, wr_ready, wr_done, wr_err, rd_gnt, rd_valid,
                                 rd_last, rd_err, st_we}), 0);
    chk("rst_st_addr", 32'(st_addr), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_slot_valid", 32'(slot_valid), 0);
    chk("rst_q_rows", 32'(q_rows), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2x3 matrix 1..6 lands in slot 0
    do_write(2, 3, 1, 6, s, e);
    chk("t1_slot", s, 0);
    chk("t1_q_rows", 32'(q_rows), 2);
    chk("t1_q_cols", 32'(q_cols), 3);
    chk("t1_valid", 32'(slot_valid), 32'h01);

    // read back with rd_ready toggling
    got.delete();
    do_read(0, 1'b1, e);
    chk("t2_err", 32'(e), 0);
    chk("t2_count", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_data", (i < got.size()) ? got[i] : -1, i + 1);

    // fill remaining slots, then victim replacement
    for (int i = 1; i < 8; i++) begin
      do_write(1, 1, 100 + i, 1, s, e);
      chk("t3_fill_slot", s, i);
    end
    chk("t3_full", 32'(slot_valid), 32'hFF);
    do_write(1, 1, 150, 1, s, e);
    chk("t3_victim0", s, 0);
    do_write(1, 1, 151, 1, s, e);
    chk("t3_victim1", s, 1);

    // simultaneous requests: writer first, reader after done + idle cycle
    got.delete();
    fork
      do_write(1, 2, 160, 2, s, e);
      begin
        bit re;
        do_read(5, 1'b0, re);
      end
    join
    chk("t4_victim2", s, 2);
    chk("t4_wr_first", 32'(t_wr_gnt < t_rd_gnt), 1);
    chk("t4_gap", t_rd_gnt - t_wr_done, 1);
    chk("t4_rd_data", (got.size() == 1) ? got[0] : -1, 105);

    // illegal dimensions
    do_write(6, 2, 0, 0, s, e);
    chk("t5_err_rows6", 32'(e), 1);
    do_write(3, 0, 0, 0, s, e);
    chk("t5_err_cols0", 32'(e), 1);

    // clear, then read of an invalid slot
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    q_slot = 3'd3;
    chk("t5_clear_valid", 32'(slot_valid), 0);
    chk("t5_clear_meta", 32'(q_rows), 0);
    do_read(3, 1'b0, e);
    chk("t5_rd_err", 32'(e), 1);

    // largest matrix, full-rate read
    q_slot = 3'd0;
    do_write(5, 5, 200, 25, s, e);
    chk("t6_slot", s, 0);
    got.delete();
    do_read(0, 1'b0, e);
    chk("t6_count", got.size(), 25);
    chk("t6_first", (got.size() > 0) ? got[0] : -1, 200);
    chk("t6_last", (got.size() == 25) ? got[24] : -1, 224);

    // reset after 3 of 25 elements
    do_write(5, 5, 300, 3, s, e);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_ctrl", 32'({wr_gnt, wr_ready, wr_done, rd_valid, st_we}), 0);
    chk("t7_rst_addr", 32'(st_addr), 0);
    chk("t7_rst_valid", 32'(slot_valid), 0);
    chk("t7_rst_meta", 32'(q_rows), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_write(1, 1, 400, 1, s, e);
    chk("t7_new_slot", s, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_storage_ctrl.md
# matrix_storage_ctrl

Single-owner controller for the 256×32 matrix storage RAM (synchronous write, combinational read). It shares the storage's single port between one matrix writer (input path) and one matrix reader (compute/display path) via request/grant. It also allocates fixed-size slots and keeps per-slot metadata (valid, rows, cols). The block sits between the UI/compute FSMs and the storage instance; nothing else drives the storage port.

## Interface
Parameters:
- `SLOTS`, 8: number of matrix slots; slot id width `SW = $clog2(SLOTS)`
- `SLOT_WORDS`, 32: words per slot; `SLOTS*SLOT_WORDS` must be ≤ 256
- `MAX_DIM`, 5: maximum rows and maximum cols
- `DW`, 32: element width

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_req`  in  1  writer request; held until `wr_gnt`
- `wr_rows`, `wr_cols`  in  3 each  dimensions; sampled at grant
- `wr_gnt`  out  1  one-cycle grant pulse
- `wr_valid` / `wr_ready`  in/out  1  element handshake
- `wr_data`  in  DW  element, row-major order
- `wr_done`  out  1  pulse after last element is written
- `wr_err`  out  1  pulse, illegal dimensions
- `wr_slot`  out  SW  slot allocated; valid with `wr_done`
- `rd_req`  in  1  reader request; held until `rd_gnt`
- `rd_slot_in`  in  SW  slot to read; sampled at grant
- `rd_gnt`  out  1  one-cycle grant pulse
- `rd_valid` / `rd_ready`  out/in  1  element handshake
- `rd_data`  out  DW  element
- `rd_last`  out  1  marks the final element
- `rd_err`  out  1  pulse, slot not valid
- `clear`  in  1  synchronous: invalidate all slots
- `q_slot`  in  SW  metadata query index
- `q_rows`, `q_cols`  out  3  combinational metadata of `q_slot`
- `slot_valid`  out  SLOTS  valid bitmap
- `st_we`  out  1  storage write enable
- `st_addr`  out  8  storage address
- `st_wdata`  out  DW  storage write data
- `st_rdata`  in  DW  storage read data (combinational)

## Operation
- FSM states: IDLE, WRITE, READ.
- **IDLE arbitration:**
  - `wr_req` has fixed priority over `rd_req`.
  - Exactly one grant pulse per cycle; requests are never granted outside IDLE.
- **Write grant:**
  - If `wr_rows` or `wr_cols` is 0 or >MAX_DIM: pulse `wr_gnt` and `wr_err` in the same cycle and stay in IDLE.
  - Otherwise allocate a slot:
    - Lowest-index invalid slot.
    - If all slots are valid: the slot at `victim` pointer, then `victim` increments mod SLOTS.
  - Clear the chosen slot's valid bit and latch its dims.
  - Element counter `idx` = 0; go to WRITE.
- **WRITE:**
  - `wr_ready` = 1.
  - `st_we` = `wr_valid`, `st_addr` = slot*SLOT_WORDS + idx, `st_wdata` = `wr_data`.
  - On each handshake, `idx`++.
  - On handshake at `idx` = rows*cols−1: set the valid bit, pulse `wr_done` with `wr_slot` next cycle, return to IDLE.
- **Read grant:**
  - If the slot is invalid: pulse `rd_gnt` and `rd_err`, stay in IDLE.
  - Otherwise `idx` = 0; go to READ.
- **READ:**
  - `rd_valid` = 1, `st_addr` = base + idx, `rd_data` = `st_rdata`.
  - `rd_last` = (idx == rows*cols−1).
  - `idx` advances on `rd_valid & rd_ready`; the handshake with `rd_last` returns to IDLE.
- **`clear`:**
  - Zeroes `slot_valid`, metadata and `victim` in any state.
  - An in-flight transfer completes normally; a WRITE in flight still sets its valid bit at completion.
- RAM contents are never erased; validity lives only in the metadata.
- Arithmetic: `idx` is 5 bits; rows*cols ≤ 25 < SLOT_WORDS, so a transfer never crosses a slot boundary.

## Timing
- Reset values:
  - State IDLE; `slot_valid`, metadata, `victim` and `idx` all 0.
  - Every output 0 (`rd_data` follows `st_rdata` only in READ, else 0).
- Grant latency: 1 cycle from `wr_req`/`rd_req` seen in IDLE (registered grant); the first element handshake is possible the cycle after grant.
- Throughput: one element per cycle with no back-pressure.
- Write: element N is in the RAM at the clock edge of its handshake; `wr_done` follows the last handshake by 1 cycle.
- Read: zero-latency combinational data path.
- Minimum idle gap: 1 cycle in IDLE between transfers.
- Reset asserted mid-transfer aborts it immediately; the partially written slot stays invalid.

## Structure
- Shared package `matrix_pkg`: SLOTS, SLOT_WORDS, MAX_DIM, DW defaults, and the state encoding (IDLE=0, WRITE=1, READ=2).
- One sub-module, `slot_alloc`: priority encoder over `~slot_valid` plus the `victim` pointer; outputs the chosen slot and a `full` flag.

## Test plan
- Write 2×3 matrix [1..6] after reset → `wr_slot`=0; `st_addr` 0..5; `q_rows`=2, `q_cols`=3; `slot_valid`=8'h01.
- Read slot 0 with `rd_ready` toggling every other cycle → data 1..6 in order, `rd_last` on 6, no duplicates or drops.
- Fill 8 slots, then write a 9th 1×1 → `wr_slot`=0 (victim); 10th → slot 1.
- Simultaneous `wr_req` and `rd_req` in IDLE → `wr_gnt` first; `rd_gnt` only after `wr_done` plus the IDLE cycle.
- `wr_rows`=6 → `wr_gnt`+`wr_err`, no `st_we`; read of invalid slot 3 → `rd_gnt`+`rd_err`.
- Assert `rst` after 3 of 25 elements → all outputs 0, `slot_valid`=0; a new write then gets slot 0.
